// File: rtl/wb_regfile_hilo.sv
// Write-back commit stage: a 32x32 GPR file plus HI/LO special registers, with
// same-cycle write-to-read bypass and saturating commit counters.
module wb_regfile_hilo #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_hilo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [CNT_W-1:0]  gpr_wr_cnt,
    output logic [CNT_W-1:0]  hilo_wr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] gpr_r [REG_NUM];
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic [CNT_W-1:0]  gpr_cnt_r;
    logic [CNT_W-1:0]  hilo_cnt_r;
    logic              gpr_we_s;

    // Writes to r0 are dropped entirely, so they neither store nor count.
    assign gpr_we_s = wb_wreg && (wb_wd != {ADDR_W{1'b0}});

    // GPR file and HI/LO storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                gpr_r[i] <= {DATA_W{1'b0}};
            end
            hi_r <= {DATA_W{1'b0}};
            lo_r <= {DATA_W{1'b0}};
        end else begin
            if (gpr_we_s) begin
                gpr_r[wb_wd] <= wb_wdata;
            end
            if (wb_hilo) begin
                hi_r <= wb_hi;
                lo_r <= wb_lo;
            end
        end
    end

    // Saturating commit counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_cnt_r  <= {CNT_W{1'b0}};
            hilo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (gpr_we_s && (gpr_cnt_r != CNT_MAX)) begin
                gpr_cnt_r <= gpr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (wb_hilo && (hilo_cnt_r != CNT_MAX)) begin
                hilo_cnt_r <= hilo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign gpr_wr_cnt  = gpr_cnt_r;
    assign hilo_wr_cnt = hilo_cnt_r;

    // Read port 1 with bypass from the in-flight write.
    always_comb begin
        rdata1 = {DATA_W{1'b0}};
        if (rst || !re1 || (raddr1 == {ADDR_W{1'b0}})) begin
            rdata1 = {DATA_W{1'b0}};
        end else if (wb_wreg && (raddr1 == wb_wd)) begin
            rdata1 = wb_wdata;
        end else begin
            rdata1 = gpr_r[raddr1];
        end
    end

    // Read port 2 with bypass from the in-flight write.
    always_comb begin
        rdata2 = {DATA_W{1'b0}};
        if (rst || !re2 || (raddr2 == {ADDR_W{1'b0}})) begin
            rdata2 = {DATA_W{1'b0}};
        end else if (wb_wreg && (raddr2 == wb_wd)) begin
            rdata2 = wb_wdata;
        end else begin
            rdata2 = gpr_r[raddr2];
        end
    end

    // HI/LO outputs with bypass from the in-flight write.
    always_comb begin
        hi_o = {DATA_W{1'b0}};
        lo_o = {DATA_W{1'b0}};
        if (rst) begin
            hi_o = {DATA_W{1'b0}};
            lo_o = {DATA_W{1'b0}};
        end else if (wb_hilo) begin
            hi_o = wb_hi;
            lo_o = wb_lo;
        end else begin
            hi_o = hi_r;
            lo_o = lo_r;
        end
    end

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Scoreboard bench for wb_regfile_hilo: a default-width instance and a 4-bit
// counter instance share stimulus; expectations come from a reference model.
module tb_wb_regfile_hilo;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_hilo;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata1, rdata2, hi_o, lo_o, gpr_wr_cnt, hilo_wr_cnt;
    logic [31:0] s_rdata1, s_rdata2, s_hi_o, s_lo_o;
    logic [3:0]  s_gpr_wr_cnt, s_hilo_wr_cnt;

    always #5 clk = ~clk;

    wb_regfile_hilo dut (
        .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_hilo(wb_hilo),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .gpr_wr_cnt(gpr_wr_cnt), .hilo_wr_cnt(hilo_wr_cnt)
    );

    wb_regfile_hilo #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_hilo(wb_hilo),
        .re1(re1), .raddr1(raddr1), .rdata1(s_rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(s_rdata2),
        .hi_o(s_hi_o), .lo_o(s_lo_o), .gpr_wr_cnt(s_gpr_wr_cnt), .hilo_wr_cnt(s_hilo_wr_cnt)
    );

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo;
    int          m_gcnt, m_hcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (rst || !re || a == 5'd0) return 32'd0;
        if (wb_wreg && a == wb_wd) return wb_wdata;
        return m_gpr[a];
    endfunction

    function automatic logic [31:0] sat4(input int c);
        return (c > 15) ? 32'd15 : c;
    endfunction

    task automatic push_exp();
        sb.push_back('{"rdata1", exp_rd(re1, raddr1)});
        sb.push_back('{"rdata2", exp_rd(re2, raddr2)});
        sb.push_back('{"hi_o", rst ? 32'd0 : (wb_hilo ? wb_hi : m_hi)});
        sb.push_back('{"lo_o", rst ? 32'd0 : (wb_hilo ? wb_lo : m_lo)});
        sb.push_back('{"gpr_wr_cnt", m_gcnt});
        sb.push_back('{"hilo_wr_cnt", m_hcnt});
        sb.push_back('{"gpr_wr_cnt_sat", sat4(m_gcnt)});
        sb.push_back('{"hilo_wr_cnt_sat", sat4(m_hcnt)});
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() != 8) begin
            chk("sb_depth", sb.size(), 32'd8);
            sb.delete();
            return;
        end
        e = sb.pop_front(); chk(e.tag, rdata1, e.v); chk({e.tag, "_s"}, s_rdata1, e.v);
        e = sb.pop_front(); chk(e.tag, rdata2, e.v); chk({e.tag, "_s"}, s_rdata2, e.v);
        e = sb.pop_front(); chk(e.tag, hi_o, e.v);   chk({e.tag, "_s"}, s_hi_o, e.v);
        e = sb.pop_front(); chk(e.tag, lo_o, e.v);   chk({e.tag, "_s"}, s_lo_o, e.v);
        e = sb.pop_front(); chk(e.tag, gpr_wr_cnt, e.v);
        e = sb.pop_front(); chk(e.tag, hilo_wr_cnt, e.v);
        e = sb.pop_front(); chk(e.tag, {28'd0, s_gpr_wr_cnt}, e.v);
        e = sb.pop_front(); chk(e.tag, {28'd0, s_hilo_wr_cnt}, e.v);
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            m_hi = 32'd0; m_lo = 32'd0; m_gcnt = 0; m_hcnt = 0;
        end else begin
            if (wb_wreg && wb_wd != 5'd0) begin
                m_gpr[wb_wd] = wb_wdata;
                m_gcnt++;
            end
            if (wb_hilo) begin
                m_hi = wb_hi; m_lo = wb_lo; m_hcnt++;
            end
        end
    endtask

    // One cycle: drive, predict, sample mid-cycle, then advance through the edge.
    task automatic cycle(input logic r, input logic wreg, input logic [4:0] wd,
                         input logic [31:0] wdata, input logic hl, input logic [31:0] h,
                         input logic [31:0] l, input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2);
        rst = r; wb_wreg = wreg; wb_wd = wd; wb_wdata = wdata;
        wb_hilo = hl; wb_hi = h; wb_lo = l;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        push_exp();
        #2;
        pop_cmp();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b1; wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'd0;
        wb_hilo = 1'b0; wb_hi = 32'd0; wb_lo = 32'd0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
        @(posedge clk);
        model_edge();
        #1;

        // Post-reset sweep of every address on both ports.
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0,
                  1'b1, 5'(i), 1'b1, 5'(31 - i));
        end

        // Bypass on both ports, then stored value.
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd5);

        // r0 write is ignored, also for re=0 reads of a live register.
        cycle(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd5);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);

        // HI/LO together with a GPR write.
        cycle(1'b0, 1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 32'hAAAA0000, 32'h0000BBBB,
              1'b1, 5'd7, 1'b1, 5'd5);
        cycle(1'b0, 1'b0, 5'd7, 32'h0, 1'b0, 32'h55555555, 32'h66666666,
              1'b1, 5'd7, 1'b1, 5'd7);

        // Writes presented during reset are discarded; outputs forced to 0.
        cycle(1'b1, 1'b1, 5'd9, 32'h11, 1'b1, 32'h1, 32'h2, 1'b1, 5'd9, 1'b1, 5'd5);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd7);
        cycle(1'b0, 1'b1, 5'd9, 32'h11, 1'b0, 32'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd9);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9);

        // Random traffic, long enough to saturate the 4-bit counters.
        for (int k = 0; k < 24; k++) begin
            cycle(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, ($urandom_range(0, 3) != 0),
                  $urandom, $urandom, ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 31)),
                  1'b1, 5'($urandom_range(0, 31)));
        end
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd1, 1'b1, 5'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/wb_regfile_hilo.md
Name: wb_regfile_hilo

Overview:
Write-back end of the MEM/WB pipeline interface. Consumes the registered write-back bundle (GPR write address/enable/data, HI/LO values and HI/LO write enable) and commits it into the 32x32 general-purpose register file and the HI/LO special registers. Provides two read ports to the decode stage and HI/LO read outputs to the execute stage, with same-cycle write-to-read bypass. Maintains saturating commit counters for debug and performance.

Parameters:
DATA_W, 32, data width of GPRs, HI and LO
ADDR_W, 5, GPR address width
REG_NUM, 32, number of GPRs; register 0 is hardwired to zero
CNT_W, 32, width of each commit counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
wb_wd  input  ADDR_W  GPR write address from MEM/WB
wb_wreg  input  1  GPR write enable from MEM/WB
wb_wdata  input  DATA_W  GPR write data from MEM/WB
wb_hi  input  DATA_W  HI write value
wb_lo  input  DATA_W  LO write value
wb_hilo  input  1  HI/LO write enable; writes HI and LO together
re1  input  1  read enable, port 1
raddr1  input  ADDR_W  read address, port 1
rdata1  output  DATA_W  read data, port 1
re2  input  1  read enable, port 2
raddr2  input  ADDR_W  read address, port 2
rdata2  output  DATA_W  read data, port 2
hi_o  output  DATA_W  current HI, bypassed
lo_o  output  DATA_W  current LO, bypassed
gpr_wr_cnt  output  CNT_W  count of committed GPR writes
hilo_wr_cnt  output  CNT_W  count of committed HI/LO writes

Behaviour:
- Reset: on posedge clk with rst=1, clear GPRs 1..31, HI, LO and both counters to 0. Any write presented in that cycle is discarded.
- While rst=1, rdata1, rdata2, hi_o and lo_o are forced to 0 combinationally.
- GPR write: on posedge clk with rst=0, wb_wreg=1 and wb_wd!=0, store wb_wdata at GPR[wb_wd]. Writes addressed to register 0 are ignored and are not counted.
- HI/LO write: on posedge clk with rst=0 and wb_hilo=1, store wb_hi into HI and wb_lo into LO. Partial writes do not exist.
- Read ports are combinational with zero-cycle latency. Port n priority:
  - rst=1 gives 0.
  - re_n=0 gives 0.
  - raddr_n=0 gives 0.
  - raddr_n==wb_wd with wb_wreg=1 gives wb_wdata (bypass).
  - Otherwise GPR[raddr_n].
- Both ports may read the same address, including the address being written; both then return the bypassed value.
- hi_o and lo_o: rst=1 gives 0; wb_hilo=1 gives wb_hi and wb_lo; otherwise the stored HI and LO.
- gpr_wr_cnt increments by 1 per committed GPR write. hilo_wr_cnt increments by 1 per committed HI/LO write.
- A cycle with both writes increments both counters.
- Counters saturate at all-ones and do not wrap. They are cleared only by reset.
- No handshake or backpressure: the upstream stage stalls by deasserting its enables, and this block always accepts.
- Reset mid-stream: the write in the reset cycle is lost. The first post-reset write commits normally on the following edge.

Test Plan:
1. Reset, then read every address on both ports with re=1 -> all rdata=0, hi_o=lo_o=0, both counters 0.
2. Write wd=5, wdata=0xDEADBEEF. Same cycle raddr1=5 -> rdata1=0xDEADBEEF (bypass). Next cycle, wreg=0, raddr2=5 -> rdata2=0xDEADBEEF; gpr_wr_cnt=1.
3. Write wd=0, wdata=0x12345678, wreg=1 -> reading address 0 returns 0 in the same cycle and afterwards; gpr_wr_cnt unchanged.
4. wb_hilo=1, hi=0xAAAA0000, lo=0x0000BBBB in the same cycle as a GPR write to r7 -> hi_o/lo_o show the new values immediately and persist after wb_hilo=0; both counters increment by 1.
5. Write r9=0x11 while rst=1 -> the r9 read after reset release returns 0 and counters stay 0. A subsequent write of r9 commits.
6. Preload gpr_wr_cnt to all-ones via a force, or use a bench with CNT_W=4 and 17 writes -> the counter holds at 0xF with no wrap.
